// File: rtl/val2_pkg.sv
// ---------------------------------------------------------------------------
// val2_pkg : shared types and count rules for the register-shift sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package val2_pkg;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  localparam int MAX_COUNT = 33;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Single-bit steps reproduce ARM's >=32 corner cases once amounts are clamped.
  function automatic logic [5:0] shift_count(input logic [1:0] sh, input logic [7:0] amt);
    logic [5:0] cnt;
    cnt = 6'd0;
    if (amt != 8'd0) begin
      case (sh)
        SH_LSL, SH_LSR: cnt = (amt > 8'(MAX_COUNT)) ? 6'(MAX_COUNT) : amt[5:0];
        SH_ASR:         cnt = (amt > 8'd32) ? 6'd32 : amt[5:0];
        default:        cnt = (amt[4:0] != 5'd0) ? {1'b0, amt[4:0]} : 6'd32;
      endcase
    end
    return cnt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/val2_shift_step.sv
// ---------------------------------------------------------------------------
// val2_shift_step : combinational shift of up to STEP bits, with last bit out
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module val2_shift_step
  import val2_pkg::*;
#(
  parameter int STEP = 4
) (
  input  logic [31:0]                 data_i,
  input  logic [1:0]                  type_i,
  input  logic [$clog2(STEP+1)-1:0]   n_i,
  output logic [31:0]                 data_o,
  output logic                        carry_o
);

  logic [5:0] n6;
  logic [4:0] lsl_idx;
  logic [4:0] rsh_idx;

  assign n6      = 6'(n_i);
  assign lsl_idx = 5'(6'd32 - n6);
  assign rsh_idx = 5'(n6 - 6'd1);

  always_comb begin
    data_o  = data_i;
    carry_o = 1'b0;
    if (n6 != 6'd0) begin
      case (type_i)
        SH_LSL: begin
          data_o  = data_i << n6;
          carry_o = data_i[lsl_idx];
        end
        SH_LSR: begin
          data_o  = data_i >> n6;
          carry_o = data_i[rsh_idx];
        end
        SH_ASR: begin
          data_o  = 32'($signed(data_i) >>> n6);
          carry_o = data_i[rsh_idx];
        end
        default: begin
          data_o  = (data_i >> n6) | (data_i << (6'd32 - n6));
          carry_o = data_i[rsh_idx];
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/val2_shift_sequencer.sv
// ---------------------------------------------------------------------------
// val2_shift_sequencer : multi-cycle register-specified shifter for Val2
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module val2_shift_sequencer
  import val2_pkg::*;
#(
  parameter int STEP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] rm,
  input  logic [1:0]  shift_type,
  input  logic [7:0]  shift_amt,
  input  logic        carry_in,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        carry_out,
  output logic        busy
);

  localparam int         NW    = $clog2(STEP + 1);
  localparam logic [5:0] STEP6 = 6'(STEP);

  state_e      state_q;
  logic [31:0] work_q;
  logic        carry_q;
  logic [5:0]  rem_q;
  logic [1:0]  type_q;
  logic        out_valid_q;
  logic        busy_q;
  logic        in_ready_q;

  logic [5:0]    count_d;
  logic [5:0]    n6;
  logic [NW-1:0] n;
  logic [31:0]   work_d;
  logic          carry_d;

  assign count_d = shift_count(shift_type, shift_amt);
  assign n6      = (rem_q < STEP6) ? rem_q : STEP6;
  assign n       = n6[NW-1:0];

  val2_shift_step #(
    .STEP (STEP)
  ) u_step (
    .data_i  (work_q),
    .type_i  (type_q),
    .n_i     (n),
    .data_o  (work_d),
    .carry_o (carry_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      work_q      <= 32'd0;
      carry_q     <= 1'b0;
      rem_q       <= 6'd0;
      type_q      <= SH_LSL;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else if (flush) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            work_q     <= rm;
            carry_q    <= carry_in;
            type_q     <= shift_type;
            rem_q      <= count_d;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b0;
            if (count_d == 6'd0) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work_q  <= work_d;
          carry_q <= carry_d;
          rem_q   <= rem_q - n6;
          if (rem_q == n6) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          // Completing handshake returns to IDLE; the next accept waits a cycle.
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = work_q;
  assign carry_out = carry_q;
  assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_val2_shift_sequencer.sv
// ---------------------------------------------------------------------------
// tb_val2_shift_sequencer : directed and random checks against an ARM shift model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_val2_shift_sequencer;

  localparam int STEP = 4;

  localparam logic [1:0] T_LSL = 2'b00;
  localparam logic [1:0] T_LSR = 2'b01;
  localparam logic [1:0] T_ASR = 2'b10;
  localparam logic [1:0] T_ROR = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] rm = 32'd0;
  logic [1:0]  shift_type = 2'b00;
  logic [7:0]  shift_amt = 8'd0;
  logic        carry_in = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        carry_out;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  val2_shift_sequencer #(
    .STEP (STEP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .rm         (rm),
    .shift_type (shift_type),
    .shift_amt  (shift_amt),
    .carry_in   (carry_in),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .carry_out  (carry_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ARM barrel-shifter semantics, {carry, result}.
  function automatic logic [32:0] arm_shift(input logic [1:0] t, input logic [31:0] v,
                                           input logic [7:0] amt, input logic cin);
    logic [63:0]        w;
    logic signed [63:0] sw;
    logic [31:0]        r;
    int                 a;
    a = int'(amt);
    if (a == 0) return {cin, v};
    case (t)
      T_LSL: begin
        w = {32'd0, v} << a;
        return {w[32], w[31:0]};
      end
      T_LSR: begin
        w = {v, 32'd0} >> a;
        return {w[31], w[63:32]};
      end
      T_ASR: begin
        if (a >= 32) return {v[31], {32{v[31]}}};
        sw = $signed({v, 32'd0}) >>> a;
        return {sw[31], sw[63:32]};
      end
      default: begin
        w = {v, v} >> (a % 32);
        r = w[31:0];
        return {r[31], r};
      end
    endcase
  endfunction

  function automatic int exp_latency(input logic [1:0] t, input logic [7:0] amt);
    int a;
    int cnt;
    a = int'(amt);
    if (a == 0)                   cnt = 0;
    else if (t == T_LSL || t == T_LSR) cnt = (a > 33) ? 33 : a;
    else if (t == T_ASR)          cnt = (a > 32) ? 32 : a;
    else                          cnt = ((a % 32) != 0) ? (a % 32) : 32;
    return (cnt + STEP - 1) / STEP + 1;
  endfunction

  task automatic run_op(input logic [1:0] t, input logic [31:0] v, input logic [7:0] amt,
                        input logic cin, input int rdly, input bit hold);
    logic [32:0] exp;
    logic [31:0] res0;
    logic        c0;
    int          lat;
    exp = arm_shift(t, v, amt, cin);
    @(negedge clk);
    in_valid   = 1'b1;
    shift_type = t;
    rm         = v;
    shift_amt  = amt;
    carry_in   = cin;
    out_ready  = 1'b0;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    lat = 1;
    if (!hold) begin
      in_valid  = 1'b0;
      rm        = $urandom;
      shift_amt = 8'($urandom);
      carry_in  = ~cin;
    end
    check("busy_after_accept", 32'(busy), 32'd1);
    check("in_ready_after_accept", 32'(in_ready), 32'd0);
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_latency(t, amt)));
    check("result", result, exp[31:0]);
    check("carry", 32'(carry_out), 32'(exp[32]));
    res0 = result;
    c0   = carry_out;
    for (int i = 0; i < rdly; i++) begin
      @(posedge clk);
      #1;
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_result", result, res0);
      check("hold_carry", 32'(carry_out), 32'(c0));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("handshake_out_valid", 32'(out_valid), 32'd0);
    check("handshake_busy", 32'(busy), 32'd0);
    check("handshake_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    bit          seen_valid;
    logic [1:0]  rt;
    logic [7:0]  ra;

    #3 rst = 1'b0;
    #4;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_carry", 32'(carry_out), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run_op(T_LSL, 32'h0000_00F1, 8'd4,   1'b0, 0, 1'b0);
    run_op(T_LSR, 32'h8000_0001, 8'd32,  1'b0, 0, 1'b0);
    run_op(T_LSL, 32'hFFFF_FFFF, 8'd33,  1'b1, 0, 1'b0);
    run_op(T_LSL, 32'h8000_0003, 8'd32,  1'b0, 0, 1'b0);
    run_op(T_ASR, 32'h8000_0000, 8'd200, 1'b0, 0, 1'b0);
    run_op(T_ASR, 32'h4000_0000, 8'd31,  1'b0, 0, 1'b0);
    run_op(T_ROR, 32'h0000_0001, 8'd33,  1'b0, 0, 1'b0);
    run_op(T_ROR, 32'h8000_0000, 8'd32,  1'b0, 0, 1'b0);
    run_op(T_ROR, 32'h1234_5678, 8'd7,   1'b0, 0, 1'b0);
    for (int k = 0; k < 4; k++)
      run_op(2'(k), 32'h1234_5678, 8'd0, 1'b1, 0, (k == 0));
    run_op(T_LSR, 32'hA5A5_0F0F, 8'd9,   1'b0, 3, 1'b1);

    // Flush in the second SHIFT cycle, with a competing request held over it.
    @(negedge clk);
    in_valid = 1'b1; shift_type = T_LSR; rm = 32'h8000_0001; shift_amt = 8'd32;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    flush = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("flush_blocks_accept", 32'(busy), 32'd0);
    flush = 1'b0;
    in_valid = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      seen_valid |= out_valid;
    end
    check("flush_no_out_valid", 32'(seen_valid), 32'd0);

    // Asynchronous reset in the middle of a shift.
    @(negedge clk);
    in_valid = 1'b1; shift_type = T_ROR; rm = 32'h1234_5679; shift_amt = 8'd31; carry_in = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_result", result, 32'd0);
    check("midrst_carry", 32'(carry_out), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_op(T_ASR, 32'hF000_1234, 8'd5, 1'b0, 1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rt = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 40));
      run_op(rt, $urandom, ra, 1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/val2_shift_sequencer.md
Name: val2_shift_sequencer

Overview:
- Multi-cycle sequencer for ARM register-specified shifts, where the amount comes from Rs[7:0]. The immediate-shift Val2 path cannot cover these.
- Sits beside the Val2 generator in EXE. It accepts Rm, the shift type, Rs[7:0] and the C flag, then iterates a narrow shifter STEP bits per cycle.
- Returns the shifted operand and the shifter carry-out over a valid/ready handshake. The hazard unit stalls the pipe while busy.

Parameters:
- STEP, 4, bits shifted per cycle. Power of two, 1..32.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-low reset (0 = reset).
- in_valid  input  1  request present.
- in_ready  output  1  request accepted when in_valid && in_ready.
- rm  input  32  operand.
- shift_type  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR.
- shift_amt  input  8  Rs[7:0].
- carry_in  input  1  current C flag.
- flush  input  1  synchronous squash of the in-flight op.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- result  output  32  shifted value (Val2).
- carry_out  output  1  shifter carry-out.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; result=0, carry_out=0, out_valid=0, busy=0.
  - in_ready = (state==IDLE), so it reads 1 during and after reset.
- States: IDLE, SHIFT, DONE.
- IDLE, on accept:
  - Load the work register with rm, carry with carry_in, and set remaining=count per the rules below.
  - Go to SHIFT if count>0, else to DONE.
- Count rules:
  - shift_amt==0, any type: count=0.
  - LSL/LSR: count=min(shift_amt,33).
  - ASR: count=min(shift_amt,32).
  - ROR with shift_amt[4:0]!=0: count=shift_amt[4:0].
  - ROR with shift_amt!=0 and shift_amt[4:0]==0: count=32.
- SHIFT, each cycle:
  - Shift by n=min(STEP,remaining) bits.
  - LSL and LSR fill with 0, ASR fills with the sign bit, ROR rotates.
  - carry = last bit shifted out. remaining -= n.
  - Go to DONE when remaining reaches 0.
- The count rules yield exact ARM semantics:
  - LSL #32 gives carry=rm[0]; LSL/LSR #>32 gives result 0, carry 0.
  - LSR #32 gives carry=rm[31].
  - ASR #>=32 gives all-sign result, carry=rm[31].
  - ROR #32k gives result=rm, carry=rm[31].
  - Amount 0 gives result=rm, carry=carry_in.
- Latency: out_valid rises ceil(count/STEP)+1 cycles after the accept edge. Minimum 1; maximum 10 at STEP=4.
- DONE:
  - out_valid=1; result and carry_out are registered and held stable while out_ready=0.
  - On out_ready: go to IDLE, out_valid=0 next cycle.
- No overlap: a new request is accepted only in IDLE. There is no accept in the same cycle as the DONE handshake.
- flush:
  - Priority over every other event. In any state, the next state is IDLE and out_valid=0.
  - flush && in_valid in IDLE: the request is not accepted.
  - flush in DONE with out_ready: the handshake is void.
- Reset mid-operation aborts immediately and discards partial results.
- Arithmetic:
  - remaining is 6 bits wide and never wraps; n is never larger than remaining.
  - shift_amt bits above those needed are ignored only through the count rules.

Decomposition:
- Shared package val2_pkg:
  - Shift-type encodings SH_LSL=2'b00, SH_LSR=2'b01, SH_ASR=2'b10, SH_ROR=2'b11.
  - State enum {IDLE, SHIFT, DONE}.
  - MAX_COUNT=33.
- Sub-module val2_shift_step (combinational):
  - Inputs: data[31:0], type, n (0..STEP).
  - Outputs: shifted data and the last bit shifted out.
  - Instantiated once; the FSM and counters live in the top.

Test Plan (STEP=4):
- LSL, rm=0x000000F1, amt=4, cin=0 -> result 0x00000F10, carry 0; out_valid exactly 2 cycles after accept.
- LSR, rm=0x80000001, amt=32 -> result 0x00000000, carry 1; out_valid 9 cycles after accept. Also LSL, rm=0xFFFFFFFF, amt=33 -> 0x00000000, carry 0.
- ASR, rm=0x80000000, amt=200 -> 0xFFFFFFFF, carry 1. ASR, rm=0x40000000, amt=31 -> 0x00000000, carry 1.
- ROR, rm=0x00000001, amt=33 -> 0x80000000, carry 1. ROR, rm=0x80000000, amt=32 -> 0x80000000, carry 1.
- amt=0, each type, rm=0x12345678, cin=1 -> result 0x12345678, carry 1; out_valid 1 cycle after accept. in_valid held in DONE -> no second accept until IDLE.
- Hold out_ready=0 for 3 cycles in DONE -> result/carry stable. Flush on the 2nd SHIFT cycle -> IDLE next cycle, out_valid never rises. rst=0 mid-SHIFT -> all outputs reset value asynchronously.
